// File: rtl/lspc2_pkg.sv
`default_nettype none
// ============================================================================
// Package  : lspc2_pkg
// Brief    : Grant encodings and VRAM slot ownership for the LSPC2 slot arbiter.
// Revision : 1.0
// ============================================================================
package lspc2_pkg;

    localparam logic [1:0] C_GNT_IDLE = 2'd0;
    localparam logic [1:0] C_GNT_SPR  = 2'd1;
    localparam logic [1:0] C_GNT_FIX  = 2'd2;
    localparam logic [1:0] C_GNT_CPU  = 2'd3;

    localparam logic [1:0] C_SLOT0_OWNER = C_GNT_SPR;
    localparam logic [1:0] C_SLOT1_OWNER = C_GNT_SPR;
    localparam logic [1:0] C_SLOT2_OWNER = C_GNT_FIX;
    localparam logic [1:0] C_SLOT3_OWNER = C_GNT_CPU;

    function automatic logic [1:0] slot_owner(input logic [1:0] slot);
        logic [1:0] owner;
        case (slot)
            2'd0:    owner = C_SLOT0_OWNER;
            2'd1:    owner = C_SLOT1_OWNER;
            2'd2:    owner = C_SLOT2_OWNER;
            default: owner = C_SLOT3_OWNER;
        endcase
        return owner;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lspc2_vram_slot_arb_if.sv
`default_nettype none
// ============================================================================
// Interface : lspc2_vram_slot_arb_if
// Brief     : Slot strobes, requester handshakes and VRAM bus of the slot arbiter.
// Revision  : 1.0
// ============================================================================
interface lspc2_vram_slot_arb_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              EN_SLOT;
    logic              EN_SYNC;
    logic              SPR_REQ;
    logic [ADDR_W-1:0] SPR_ADDR;
    logic              SPR_ACK;
    logic              FIX_REQ;
    logic [ADDR_W-1:0] FIX_ADDR;
    logic              FIX_ACK;
    logic              CPU_WR_REQ;
    logic [ADDR_W-1:0] CPU_ADDR;
    logic [DATA_W-1:0] CPU_DATA;
    logic              CPU_WR_ACK;
    logic              CPU_BUSY;
    logic [ADDR_W-1:0] VRAM_ADDR;
    logic [DATA_W-1:0] VRAM_WDATA;
    logic              VRAM_OE;
    logic              VRAM_WE;
    logic [1:0]        GNT;

    modport slave (
        input  EN_SLOT, EN_SYNC,
        input  SPR_REQ, SPR_ADDR, FIX_REQ, FIX_ADDR, CPU_WR_REQ, CPU_ADDR, CPU_DATA,
        output SPR_ACK, FIX_ACK, CPU_WR_ACK, CPU_BUSY,
        output VRAM_ADDR, VRAM_WDATA, VRAM_OE, VRAM_WE, GNT
    );

    modport master (
        output EN_SLOT, EN_SYNC,
        output SPR_REQ, SPR_ADDR, FIX_REQ, FIX_ADDR, CPU_WR_REQ, CPU_ADDR, CPU_DATA,
        input  SPR_ACK, FIX_ACK, CPU_WR_ACK, CPU_BUSY,
        input  VRAM_ADDR, VRAM_WDATA, VRAM_OE, VRAM_WE, GNT
    );
endinterface
`default_nettype wire

// File: rtl/lspc2_vram_wbuf.sv
`default_nettype none
// ============================================================================
// Module   : lspc2_vram_wbuf
// Brief    : CPU VRAM write buffer; 4-entry FIFO when LSPC_VRAM_WFIFO_EN is
//            defined, otherwise a single holding register.
// Revision : 1.0
// ============================================================================
module lspc2_vram_wbuf #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              i_push,
    input  wire logic [ADDR_W-1:0] i_addr,
    input  wire logic [DATA_W-1:0] i_data,
    input  wire logic              i_pop,
    output logic      [ADDR_W-1:0] o_head_addr,
    output logic      [DATA_W-1:0] o_head_data,
    output logic                   o_empty,
    output logic                   o_full
);
`ifdef LSPC_VRAM_WFIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    if (DEPTH > 1) begin : g_fifo
        localparam int PTR_W = $clog2(DEPTH);

        logic [ADDR_W+DATA_W-1:0] r_mem [DEPTH];
        logic [PTR_W-1:0]         r_wr_ptr;
        logic [PTR_W-1:0]         r_rd_ptr;
        logic [PTR_W:0]           r_count;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (i_push) begin
                    r_mem[r_wr_ptr] <= {i_addr, i_data};
                    r_wr_ptr        <= r_wr_ptr + 1'b1;
                end
                if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
                if (i_push && !i_pop)      r_count <= r_count + 1'b1;
                else if (!i_push && i_pop) r_count <= r_count - 1'b1;
            end
        end

        assign {o_head_addr, o_head_data} = r_mem[r_rd_ptr];
        assign o_empty = (r_count == '0);
        assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    end else begin : g_reg
        logic [ADDR_W+DATA_W-1:0] r_data;
        logic                     r_valid;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_data  <= '0;
                r_valid <= 1'b0;
            end else if (i_push) begin
                r_data  <= {i_addr, i_data};
                r_valid <= 1'b1;
            end else if (i_pop) begin
                r_valid <= 1'b0;
            end
        end

        assign {o_head_addr, o_head_data} = r_data;
        assign o_empty = ~r_valid;
        assign o_full  = r_valid;
    end

endmodule
`default_nettype wire

// File: rtl/lspc2_vram_slot_arb.sv
`default_nettype none
// ============================================================================
// Module   : lspc2_vram_slot_arb
// Brief    : Four-slot VRAM time-division arbiter (sprite, sprite, fix, CPU)
//            with buffered CPU writes; LSPC_VRAM_WFIFO_EN selects a 4-deep buffer.
// Revision : 1.0
// ============================================================================
module lspc2_vram_slot_arb
    import lspc2_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  wire logic            CLK,
    input  wire logic            nRESETP,
    lspc2_vram_slot_arb_if.slave bus
);

    logic [1:0]        r_slot_cnt;
    logic              r_sync_pend;
    logic [1:0]        r_gnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_oe;
    logic              r_we;
    logic              r_spr_ack;
    logic              r_fix_ack;
    logic              r_wr_ack;

    logic              w_sync_now;
    logic [1:0]        w_slot;
    logic [1:0]        w_owner;
    logic              w_owner_req;
    logic [1:0]        w_gnt;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_push;
    logic              w_pop;
    logic              w_wb_empty;
    logic              w_wb_full;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;

    lspc2_vram_wbuf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_wbuf (
        .clk         (CLK),
        .rst_n       (nRESETP),
        .i_push      (w_push),
        .i_addr      (bus.CPU_ADDR),
        .i_data      (bus.CPU_DATA),
        .i_pop       (w_pop),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data),
        .o_empty     (w_wb_empty),
        .o_full      (w_wb_full)
    );

    // A sync seen in the strobe cycle itself restarts the frame at once.
    always_comb begin
        w_sync_now  = r_sync_pend | bus.EN_SYNC;
        w_slot      = w_sync_now ? 2'd0 : r_slot_cnt;
        w_owner     = slot_owner(w_slot);
        w_owner_req = 1'b0;
        case (w_owner)
            C_GNT_SPR: w_owner_req = bus.SPR_REQ;
            C_GNT_FIX: w_owner_req = bus.FIX_REQ;
            C_GNT_CPU: w_owner_req = ~w_wb_empty;
            default:   w_owner_req = 1'b0;
        endcase

        w_gnt = C_GNT_IDLE;
        if (w_owner_req)      w_gnt = w_owner;
        else if (!w_wb_empty) w_gnt = C_GNT_CPU;

        w_addr  = '0;
        w_wdata = '0;
        case (w_gnt)
            C_GNT_SPR: w_addr = bus.SPR_ADDR;
            C_GNT_FIX: w_addr = bus.FIX_ADDR;
            C_GNT_CPU: begin
                w_addr  = w_head_addr;
                w_wdata = w_head_data;
            end
            default: ;
        endcase
    end

    // Full is judged on the registered count, so a pop never frees a push slot in the same cycle.
    assign w_push = bus.CPU_WR_REQ & ~w_wb_full;
    assign w_pop  = bus.EN_SLOT & (w_gnt == C_GNT_CPU);

    always_ff @(posedge CLK or negedge nRESETP) begin
        if (!nRESETP) begin
            r_slot_cnt  <= 2'd0;
            r_sync_pend <= 1'b0;
        end else if (bus.EN_SLOT) begin
            r_slot_cnt  <= w_slot + 2'd1;
            r_sync_pend <= 1'b0;
        end else if (bus.EN_SYNC) begin
            r_sync_pend <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRESETP) begin
        if (!nRESETP) begin
            r_gnt     <= C_GNT_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_oe      <= 1'b0;
            r_we      <= 1'b0;
            r_spr_ack <= 1'b0;
            r_fix_ack <= 1'b0;
            r_wr_ack  <= 1'b0;
        end else begin
            r_wr_ack <= w_push;
            if (bus.EN_SLOT) begin
                r_gnt     <= w_gnt;
                r_addr    <= w_addr;
                r_wdata   <= w_wdata;
                r_oe      <= (w_gnt == C_GNT_SPR) | (w_gnt == C_GNT_FIX);
                r_we      <= (w_gnt == C_GNT_CPU);
                r_spr_ack <= (w_gnt == C_GNT_SPR);
                r_fix_ack <= (w_gnt == C_GNT_FIX);
            end else begin
                r_spr_ack <= 1'b0;
                r_fix_ack <= 1'b0;
            end
        end
    end

    assign bus.GNT        = r_gnt;
    assign bus.VRAM_ADDR  = r_addr;
    assign bus.VRAM_WDATA = r_wdata;
    assign bus.VRAM_OE    = r_oe;
    assign bus.VRAM_WE    = r_we;
    assign bus.SPR_ACK    = r_spr_ack;
    assign bus.FIX_ACK    = r_fix_ack;
    assign bus.CPU_WR_ACK = r_wr_ack;
    assign bus.CPU_BUSY   = ~w_wb_empty;

endmodule
`default_nettype wire

// File: tb/tb_lspc2_vram_slot_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_lspc2_vram_slot_arb
// Brief    : Scoreboard bench for the VRAM slot arbiter against a frame-level model.
// Revision : 1.0
// ============================================================================
module tb_lspc2_vram_slot_arb;
`ifdef LSPC_VRAM_WFIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    typedef struct packed {
        logic [1:0]  gnt;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        oe;
        logic        we;
    } exp_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    logic CLK     = 1'b0;
    logic nRESETP = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    int   acks    = 0;
    int   spr_mode = 0;
    int   fix_mode = 0;

    wr_t  wq[$];
    wr_t  m_q[$];
    exp_t exp_q[$];
    exp_t m_cur = '0;
    int   m_pos = 0;
    bit   m_sync = 0;
    bit   m_evt = 0;
    bit   m_spr_ack = 0;
    bit   m_fix_ack = 0;
    bit   m_wr_ack = 0;

    lspc2_vram_slot_arb_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    lspc2_vram_slot_arb #(.ADDR_W(16), .DATA_W(16)) dut (
        .CLK     (CLK),
        .nRESETP (nRESETP),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ctrl_flat();
        return {24'd0, bus.GNT, bus.VRAM_OE, bus.VRAM_WE, bus.SPR_ACK, bus.FIX_ACK,
                bus.CPU_WR_ACK, bus.CPU_BUSY};
    endfunction

    // Reference model: frame position, pending sync and the write queue, updated per clock.
    initial begin
        int   n;
        int   slot;
        logic [1:0] owner;
        bit   owner_req;
        exp_t r;
        forever begin
            @(posedge CLK or negedge nRESETP);
            if (!nRESETP) begin
                m_q.delete();
                exp_q.delete();
                m_cur     = '0;
                m_pos     = 0;
                m_sync    = 0;
                m_evt     = 0;
                m_spr_ack = 0;
                m_fix_ack = 0;
                m_wr_ack  = 0;
            end else begin
                n         = m_q.size();
                m_evt     = 0;
                m_spr_ack = 0;
                m_fix_ack = 0;
                if (bus.EN_SLOT) begin
                    slot   = (m_sync || bus.EN_SYNC) ? 0 : m_pos;
                    m_pos  = (slot + 1) % 4;
                    m_sync = 0;
                    owner  = (slot < 2) ? 2'd1 : (slot == 2) ? 2'd2 : 2'd3;
                    owner_req = (owner == 2'd1) ? bus.SPR_REQ :
                                (owner == 2'd2) ? bus.FIX_REQ : (n > 0);
                    r = '0;
                    if (owner_req)  r.gnt = owner;
                    else if (n > 0) r.gnt = 2'd3;
                    case (r.gnt)
                        2'd1: begin r.addr = bus.SPR_ADDR; r.oe = 1'b1; end
                        2'd2: begin r.addr = bus.FIX_ADDR; r.oe = 1'b1; end
                        2'd3: begin
                            r.addr  = m_q[0].addr;
                            r.wdata = m_q[0].data;
                            r.we    = 1'b1;
                            void'(m_q.pop_front());
                        end
                        default: ;
                    endcase
                    exp_q.push_back(r);
                    m_evt     = 1;
                    m_spr_ack = (r.gnt == 2'd1);
                    m_fix_ack = (r.gnt == 2'd2);
                end else if (bus.EN_SYNC) begin
                    m_sync = 1;
                end
                m_wr_ack = bus.CPU_WR_REQ && (n < DEPTH);
                if (m_wr_ack) m_q.push_back('{bus.CPU_ADDR, bus.CPU_DATA});
            end
        end
    end

    // Monitor: consumes the expected grant when a slot result appears, then checks held outputs.
    initial begin
        forever begin
            @(negedge CLK);
            if (nRESETP) begin
                if (m_evt) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL scoreboard_underflow: actual empty expected entry");
                    end else begin
                        m_cur = exp_q.pop_front();
                    end
                end
                chk("gnt",        bus.GNT,        m_cur.gnt);
                chk("vram_addr",  bus.VRAM_ADDR,  m_cur.addr);
                chk("vram_wdata", bus.VRAM_WDATA, m_cur.wdata);
                chk("vram_oe",    bus.VRAM_OE,    m_cur.oe);
                chk("vram_we",    bus.VRAM_WE,    m_cur.we);
                chk("spr_ack",    bus.SPR_ACK,    m_spr_ack);
                chk("fix_ack",    bus.FIX_ACK,    m_fix_ack);
                chk("cpu_wr_ack", bus.CPU_WR_ACK, m_wr_ack);
                chk("cpu_busy",   bus.CPU_BUSY,   m_q.size() > 0);
            end
        end
    end

    // Sprite / fix requesters: hold REQ and ADDR until ACK.
    initial begin
        bus.SPR_REQ = 0; bus.SPR_ADDR = '0;
        bus.FIX_REQ = 0; bus.FIX_ADDR = '0;
        forever begin
            @(negedge CLK);
            if (bus.SPR_ACK || spr_mode == 0) bus.SPR_REQ = 0;
            if (!bus.SPR_REQ && (spr_mode == 1 || (spr_mode == 2 && $urandom_range(0, 2) == 0))) begin
                bus.SPR_REQ  = 1;
                bus.SPR_ADDR = 16'($urandom);
            end
            if (bus.FIX_ACK || fix_mode == 0) bus.FIX_REQ = 0;
            if (!bus.FIX_REQ && (fix_mode == 1 || (fix_mode == 2 && $urandom_range(0, 2) == 0))) begin
                bus.FIX_REQ  = 1;
                bus.FIX_ADDR = 16'($urandom);
            end
        end
    end

    // CPU writer: presents queued writes back to back, advancing on each ACK.
    initial begin
        wr_t w;
        bus.CPU_WR_REQ = 0; bus.CPU_ADDR = '0; bus.CPU_DATA = '0;
        forever begin
            @(negedge CLK);
            if (bus.CPU_WR_ACK && wq.size() > 0) begin
                w = wq.pop_front();
                acks++;
            end
            if (wq.size() > 0) begin
                bus.CPU_WR_REQ = 1;
                bus.CPU_ADDR   = wq[0].addr;
                bus.CPU_DATA   = wq[0].data;
            end else begin
                bus.CPU_WR_REQ = 0;
            end
        end
    end

    task automatic slot(input bit sync, input int gap);
        @(negedge CLK);
        bus.EN_SLOT = 1; bus.EN_SYNC = sync;
        @(negedge CLK);
        bus.EN_SLOT = 0; bus.EN_SYNC = 0;
        repeat (gap) @(negedge CLK);
    endtask

    task automatic sync_only();
        @(negedge CLK); bus.EN_SYNC = 1;
        @(negedge CLK); bus.EN_SYNC = 0;
    endtask

    task automatic wait_acks(input int target, input string name);
        int n = 0;
        while (acks < target && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk(name, acks, target);
    endtask

    initial begin
        logic [1:0] eg [4];
        int a0;
        int tgt;
        eg[0] = 2'd1; eg[1] = 2'd1; eg[2] = 2'd2; eg[3] = 2'd0;
        bus.EN_SLOT = 0; bus.EN_SYNC = 0;

        repeat (3) @(negedge CLK);
        chk("reset_ctrl",  ctrl_flat(),    32'd0);
        chk("reset_addr",  bus.VRAM_ADDR,  32'd0);
        chk("reset_wdata", bus.VRAM_WDATA, 32'd0);
        @(negedge CLK); #1 nRESETP = 1;

        // Full frame with both fetchers requesting and no CPU traffic.
        spr_mode = 1; fix_mode = 1;
        repeat (2) @(negedge CLK);
        sync_only();
        for (int i = 0; i < 4; i++) begin
            slot(0, 1);
            chk($sformatf("frame_gnt%0d", i), bus.GNT, eg[i]);
            chk($sformatf("frame_oe%0d", i), bus.VRAM_OE, (i < 3) ? 1 : 0);
        end

        // Single CPU write serviced in a sprite slot left unclaimed.
        spr_mode = 0; fix_mode = 0;
        repeat (2) @(negedge CLK);
        a0 = acks;
        wq.push_back('{16'h1234, 16'hBEEF});
        wait_acks(a0 + 1, "cpu_single_ack");
        slot(1, 0);
        chk("cpu_gnt",   bus.GNT,        32'd3);
        chk("cpu_we_oe", {bus.VRAM_WE, bus.VRAM_OE}, 32'd2);
        chk("cpu_addr",  bus.VRAM_ADDR,  32'h1234);
        chk("cpu_data",  bus.VRAM_WDATA, 32'hBEEF);
        chk("cpu_busy_after", bus.CPU_BUSY, 32'd0);

        // Five writes back to back: buffer fills, the next waits for a pop.
        a0 = acks;
        for (int i = 0; i < 5; i++) wq.push_back('{16'(16'h0100 + i), 16'($urandom)});
        repeat (12) @(negedge CLK);
        chk("wbuf_acks_full", acks - a0, DEPTH);
        chk("wbuf_busy_full", bus.CPU_BUSY, 32'd1);
        slot(0, 3);
        chk("wbuf_acks_after_pop", acks - a0, DEPTH + 1);
        for (int i = 0; i < 30 && (wq.size() > 0 || bus.CPU_BUSY); i++) slot(0, 1);
        chk("wbuf_drained", {wq.size() == 0, bus.CPU_BUSY}, 32'd2);

        // Sync colliding with a strobe mid-frame restarts at slot 0.
        spr_mode = 1; fix_mode = 1;
        repeat (2) @(negedge CLK);
        slot(1, 1);
        slot(0, 1);
        slot(1, 1);
        chk("sync_mid_slot0", bus.GNT, 32'd1);
        slot(0, 1);
        chk("sync_mid_slot1", bus.GNT, 32'd1);
        slot(0, 1);
        chk("sync_mid_slot2", bus.GNT, 32'd2);

        // Reset during a CPU grant with entries still buffered.
        spr_mode = 0; fix_mode = 0;
        repeat (2) @(negedge CLK);
        a0  = acks;
        tgt = (DEPTH >= 3) ? 3 : DEPTH;
        for (int i = 0; i < 3; i++) wq.push_back('{16'(16'h0200 + i), 16'($urandom)});
        wait_acks(a0 + tgt, "rst_prefill_acks");
        slot(0, 0);
        chk("rst_pre_gnt", bus.GNT, 32'd3);
        #1;
        nRESETP = 0;
        wq.delete();
        bus.CPU_WR_REQ = 0;
        #1;
        chk("rst_ctrl",  ctrl_flat(),    32'd0);
        chk("rst_addr",  bus.VRAM_ADDR,  32'd0);
        chk("rst_wdata", bus.VRAM_WDATA, 32'd0);
        @(negedge CLK); #1 nRESETP = 1;
        for (int i = 0; i < 6; i++) begin
            slot(0, 1);
            chk("rst_no_replay", {bus.GNT, bus.VRAM_WE}, 32'd0);
        end

        // Randomized traffic.
        spr_mode = 2; fix_mode = 2;
        for (int k = 0; k < 250; k++) begin
            if ($urandom_range(0, 2) == 0 && wq.size() < 6)
                wq.push_back('{16'($urandom), 16'($urandom)});
            if ($urandom_range(0, 15) == 0) sync_only();
            slot($urandom_range(0, 9) == 0, $urandom_range(0, 3));
        end
        spr_mode = 0; fix_mode = 0;
        repeat (5) @(negedge CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
